// File: rtl/truth_table_sweeper.sv
// Walks a 3-input gate through combinations 000..111 and builds its 8-bit truth-table code; start-to-done = 8*(SETTLE_CYCLES+1)+1 cycles.
// start is ignored while busy, with no queueing. Define TT_SWEEPER_CHECK_EN to add the expected-code comparison ports.
module truth_table_sweeper #(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       in1,
   output logic       in2,
   output logic       in3,
   input  logic       gate_out,
   output logic       busy,
   output logic       done,
   output logic [7:0] tt_code
`ifdef TT_SWEEPER_CHECK_EN
   ,
   input  logic [7:0] expected,
   output logic       mismatch,
   output logic [2:0] first_fail_idx
`endif
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   state_t           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [2:0]       combo_q, combo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [7:0]       tt_q, tt_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= 3'd0;
         combo_q <= 3'd0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         tt_q    <= 8'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         combo_q <= combo_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         tt_q    <= tt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      combo_d = combo_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      tt_d    = tt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               idx_d   = 3'd0;
               combo_d = 3'd0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               if (SETTLE_CYCLES == 0) state_d = S_SAMPLE;
               else                    state_d = S_SETTLE;
            end
         end
         S_SETTLE: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            // combination idx lands in bit (7-idx), so idx 0 is the MSB
            tt_d[3'd7 - idx_q] = gate_out;
            if (idx_q == 3'd7) begin
               combo_d = 3'd0;
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + 3'd1;
               combo_d = idx_q + 3'd1;
               cnt_d   = '0;
               if (SETTLE_CYCLES == 0) state_d = S_SAMPLE;
               else                    state_d = S_SETTLE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            combo_d = 3'd0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign in1     = combo_q[2];
   assign in2     = combo_q[1];
   assign in3     = combo_q[0];
   assign busy    = busy_q;
   assign done    = (state_q == S_DONE);
   assign tt_code = tt_q;

`ifdef TT_SWEEPER_CHECK_EN
   logic [7:0] diff;
   logic       mismatch_q;
   logic [2:0] ffi_q;

   assign diff = tt_q ^ expected;

   // highest differing bit position corresponds to the lowest combination index
   function automatic logic [2:0] lowest_idx(input logic [7:0] d);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (d[i]) r = 3'(7 - i);
      end
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mismatch_q <= 1'b0;
         ffi_q      <= 3'd0;
      end else if (state_q == S_IDLE && start) begin
         mismatch_q <= 1'b0;
         ffi_q      <= 3'd0;
      end else if (state_q == S_DONE) begin
         mismatch_q <= |diff;
         ffi_q      <= lowest_idx(diff);
      end
   end

   assign mismatch       = mismatch_q;
   assign first_fail_idx = ffi_q;
`endif

endmodule
